decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 202 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RISC-V ID stage: IF/ID register, 32x32 register file, immediate generator and main/ALU decoder.
// Latency: 1 cycle from fetch to decoded outputs; reads are combinational (write-through when DECODE_RF_BYPASS_EN is defined).
// Backpressure: StallD holds the IF/ID register and FlushD loads a NOP bubble; register-file writes are never blocked.
module decode_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrF,
    input  logic [31:0] PCF,
    input  logic [31:0] PCPlus4F,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    output logic [31:0] RD1D,
    output logic [31:0] RD2D,
    output logic [31:0] ImmExtD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic [4:0]  RdD,
    output logic        RegWriteD,
    output logic        MemWriteD,
    output logic        JumpD,
    output logic        BranchD,
    output logic        ALUSrcD,
    output logic        IllegalD,
    output logic [1:0]  ResultSrcD,
    output logic [2:0]  ALUControlD
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BRNCH = 7'b1100011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] rf_q [32];

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        rf_we;

    // ---------------- IF/ID register: rst > FlushD > StallD > load ----------------
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        if (FlushD) begin
            instr_d    = NOP_INSTR;
            pc_d       = '0;
            pc_plus4_d = '0;
        end else if (!StallD) begin
            instr_d    = InstrF;
            pc_d       = PCF;
            pc_plus4_d = PCPlus4F;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign PCD      = pc_q;
    assign PCPlus4D = pc_plus4_q;
    assign opcode   = instr_q[6:0];
    assign funct3   = instr_q[14:12];
    assign funct7_b5 = instr_q[30];
    assign Rs1D     = instr_q[19:15];
    assign Rs2D     = instr_q[24:20];
    assign RdD      = instr_q[11:7];

    // ---------------- Register file ----------------
    assign rf_we = RegWriteW && (RdW != 5'd0) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[RdW] <= ResultW;
        end
    end

    always_comb begin
        RD1D = (Rs1D == 5'd0) ? 32'd0 : rf_q[Rs1D];
        RD2D = (Rs2D == 5'd0) ? 32'd0 : rf_q[Rs2D];
`ifdef DECODE_RF_BYPASS_EN
        // rf_we already excludes x0, so the forward can never expose a write to x0
        if (rf_we && (RdW == Rs1D)) RD1D = ResultW;
        if (rf_we && (RdW == Rs2D)) RD2D = ResultW;
`endif
    end

    // ---------------- Immediate generator ----------------
    always_comb begin
        ImmExtD = '0;
        case (opcode)
            OP_LOAD, OP_ALUI, OP_JALR:
                ImmExtD = {{20{instr_q[31]}}, instr_q[31:20]};
            OP_STORE:
                ImmExtD = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            OP_BRNCH:
                ImmExtD = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                           instr_q[30:25], instr_q[11:8], 1'b0};
            OP_JAL:
                ImmExtD = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                           instr_q[20], instr_q[30:21], 1'b0};
            default:
                ImmExtD = '0;
        endcase
    end

    // ---------------- Main and ALU decoder ----------------
    logic reg_write;

    always_comb begin
        reg_write   = 1'b0;
        MemWriteD   = 1'b0;
        JumpD       = 1'b0;
        BranchD     = 1'b0;
        ALUSrcD     = 1'b0;
        ResultSrcD  = 2'b00;
        ALUControlD = ALU_ADD;
        IllegalD    = 1'b0;

        case (opcode)
            OP_LOAD: begin
                reg_write  = 1'b1;
                ALUSrcD    = 1'b1;
                ResultSrcD = 2'b01;
                IllegalD   = (funct3 != 3'b010);
            end
            OP_STORE: begin
                MemWriteD = 1'b1;
                ALUSrcD   = 1'b1;
                IllegalD  = (funct3 != 3'b010);
            end
            OP_BRNCH: begin
                BranchD     = 1'b1;
                ALUControlD = ALU_SUB;
                IllegalD    = (funct3 != 3'b000);
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                JumpD      = 1'b1;
                ResultSrcD = 2'b10;
            end
            OP_RTYPE, OP_ALUI: begin
                reg_write = 1'b1;
                ALUSrcD   = (opcode == OP_ALUI);
                case (funct3)
                    // bit 30 of an I-type is immediate data, so sub is R-type only
                    3'b000: ALUControlD = (opcode == OP_RTYPE && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b010: ALUControlD = ALU_SLT;
                    3'b110: ALUControlD = ALU_OR;
                    3'b111: ALUControlD = ALU_AND;
                    default: IllegalD = 1'b1;
                endcase
            end
            default: IllegalD = 1'b1;
        endcase

        if (IllegalD) begin
            reg_write   = 1'b0;
            MemWriteD   = 1'b0;
            JumpD       = 1'b0;
            BranchD     = 1'b0;
            ALUSrcD     = 1'b0;
            ResultSrcD  = 2'b00;
            ALUControlD = ALU_ADD;
        end
    end

    // A write to x0 has no effect, so report it as no write; the NOP bubble then reads RegWriteD=0
    assign RegWriteD = reg_write && (RdD != 5'd0);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, IF/ID stall/flush priority, register file, immediates and decode.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] InstrF, PCF, PCPlus4F;
    logic        StallD, FlushD;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, IllegalD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD;

    int vectors = 0;
    int miscompares = 0;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .StallD(StallD), .FlushD(FlushD),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .PCD(PCD), .PCPlus4D(PCPlus4D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .IllegalD(IllegalD),
        .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] instr, input logic [31:0] pc);
        InstrF   = instr;
        PCF      = pc;
        PCPlus4F = pc + 32'd4;
        tick();
    endtask

    task automatic check_ctrl(input string tag, input logic rw, input logic mw, input logic j,
                              input logic b, input logic as, input logic [1:0] rs,
                              input logic [2:0] alu, input logic ill);
        check({tag, ".RegWriteD"},   32'(RegWriteD),   32'(rw));
        check({tag, ".MemWriteD"},   32'(MemWriteD),   32'(mw));
        check({tag, ".JumpD"},       32'(JumpD),       32'(j));
        check({tag, ".BranchD"},     32'(BranchD),     32'(b));
        check({tag, ".ALUSrcD"},     32'(ALUSrcD),     32'(as));
        check({tag, ".ResultSrcD"},  32'(ResultSrcD),  32'(rs));
        check({tag, ".ALUControlD"}, 32'(ALUControlD), 32'(alu));
        check({tag, ".IllegalD"},    32'(IllegalD),    32'(ill));
    endtask

    initial begin
        rst = 1'b1; InstrF = '0; PCF = '0; PCPlus4F = '0;
        StallD = 1'b0; FlushD = 1'b0; RegWriteW = 1'b0; RdW = '0; ResultW = '0;

        // Reset: NOP in the IF/ID slot
        tick();
        rst = 1'b0;
        check("rst.PCD", PCD, 32'd0);
        check("rst.PCPlus4D", PCPlus4D, 32'd0);
        check("rst.RD1D", RD1D, 32'd0);
        check("rst.RD2D", RD2D, 32'd0);
        check("rst.ImmExtD", ImmExtD, 32'd0);
        check("rst.RdD", 32'(RdD), 32'd0);
        check_ctrl("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0);

        // addi x1,x0,5 at PC 8
        load(32'h00500093, 32'h8);
        check("addi.PCD", PCD, 32'd8);
        check("addi.PCPlus4D", PCPlus4D, 32'd12);
        check("addi.RdD", 32'(RdD), 32'd1);
        check("addi.Rs1D", 32'(Rs1D), 32'd0);
        check("addi.ImmExtD", ImmExtD, 32'd5);
        check_ctrl("addi", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0);

        // Stall holds for 3 cycles while fetch presents something else
        StallD = 1'b1;
        InstrF = 32'h0000007F; PCF = 32'h100; PCPlus4F = 32'h104;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.PCD", PCD, 32'd8);
            check("stall.RdD", 32'(RdD), 32'd1);
            check("stall.ImmExtD", ImmExtD, 32'd5);
        end

        // Flush overrides stall
        FlushD = 1'b1;
        tick();
        check("flush.PCD", PCD, 32'd0);
        check("flush.PCPlus4D", PCPlus4D, 32'd0);
        check("flush.RdD", 32'(RdD), 32'd0);
        check("flush.ImmExtD", ImmExtD, 32'd0);
        check_ctrl("flush", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0);
        FlushD = 1'b0; StallD = 1'b0;

        // add x3,x2,x0 reads x2 (still 0)
        load(32'h000101B3, 32'h20);
        check("add.Rs1D", 32'(Rs1D), 32'd2);
        check("add.RD1D.before", RD1D, 32'd0);
        check_ctrl("add", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0);

        // Write x2 while stalled; same-cycle visibility depends on the bypass build
        StallD = 1'b1;
        RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'hDEADBEEF;
        #1;
`ifdef DECODE_RF_BYPASS_EN
        check("wr.RD1D.same", RD1D, 32'hDEADBEEF);
`else
        check("wr.RD1D.same", RD1D, 32'd0);
`endif
        tick();
        RegWriteW = 1'b0;
        #1;
        check("wr.RD1D.next", RD1D, 32'hDEADBEEF);

        // Write to x0 is ignored (rs2 of the held instruction is x0)
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h12345678;
        #1;
        check("x0.RD2D.same", RD2D, 32'd0);
        tick();
        RegWriteW = 1'b0;
        #1;
        check("x0.RD2D.next", RD2D, 32'd0);

        // Write while stalled and flushed still lands
        FlushD = 1'b1;
        RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'h0000_00A5;
        tick();
        RegWriteW = 1'b0; FlushD = 1'b0; StallD = 1'b0;
        load(32'h000101B3, 32'h24);
        check("flushwr.RD1D", RD1D, 32'h0000_00A5);

        // Reset wins over a simultaneous write, and clears x2
        rst = 1'b1; StallD = 1'b1;
        RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'h5555_5555;
        tick();
        rst = 1'b0; StallD = 1'b0; RegWriteW = 1'b0;
        check("rstwr.PCD", PCD, 32'd0);
        load(32'h000101B3, 32'h28);
        check("rstwr.RD1D", RD1D, 32'd0);

        // beq x0,x0,-4
        load(32'hFE000EE3, 32'h30);
        check("beq.ImmExtD", ImmExtD, 32'hFFFFFFFC);
        check_ctrl("beq", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b001, 1'b0);

        // sw x2,8(x1)
        load(32'h0020A423, 32'h34);
        check("sw.ImmExtD", ImmExtD, 32'd8);
        check_ctrl("sw", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0);

        // lw x5,-4(x1)
        load(32'hFFC0A283, 32'h38);
        check("lw.ImmExtD", ImmExtD, 32'hFFFFFFFC);
        check("lw.RdD", 32'(RdD), 32'd5);
        check_ctrl("lw", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b000, 1'b0);

        // jal x1,16
        load(32'h010000EF, 32'h3C);
        check("jal.ImmExtD", ImmExtD, 32'd16);
        check_ctrl("jal", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'b000, 1'b0);

        // sub / and / ori / slti / addi with imm bit 30 set
        load(32'h402081B3, 32'h40);
        check_ctrl("sub", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b001, 1'b0);
        load(32'h0020F1B3, 32'h44);
        check_ctrl("and", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 1'b0);
        load(32'h0000E093, 32'h48);
        check_ctrl("ori", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b011, 1'b0);
        load(32'h0000A093, 32'h4C);
        check_ctrl("slti", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b101, 1'b0);
        load(32'h40000093, 32'h50);
        check("addi400.ImmExtD", ImmExtD, 32'h00000400);
        check_ctrl("addi400", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0);

        // Unsupported funct3 (sll)
        load(32'h000011B3, 32'h54);
        check_ctrl("sll", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1);

        // Unlisted opcode
        load(32'h0000007F, 32'h58);
        check("ill.ImmExtD", ImmExtD, 32'd0);
        check_ctrl("ill", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
